regbus_arbiter: RTL and testbench

Shares one accelerator register port among NUM_REQ requesters, for example the AXI4-Lite bridge and an internal config sequencer. The port is the set_addr/set_data/set_stb write side plus the get_addr/get_data/get_stb read side. The block arbitrates round-robin, issues one register access at a time, and returns a response to the granted requester. It sits between the requesters and the accelerator register file.

---
 rtl/regbus_arbiter.sv | 113 +++++++++++
 tb/tb_regbus_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbus_arbiter.sv
// Round-robin arbiter sharing one accelerator register port (set_*/get_*) among NUM_REQ requesters.
// Define REGBUS_ARB_PRIO_EN to give requester 0 fixed top priority over the round-robin group.
module regbus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [DATA_WIDTH-1:0]         set_addr,
  output logic [DATA_WIDTH-1:0]         set_data,
  output logic                          set_stb,
  output logic [DATA_WIDTH-1:0]         get_addr,
  input  logic [DATA_WIDTH-1:0]         get_data,
  output logic                          get_stb,
  output logic                          busy
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [NUM_REQ-1:0] LSB = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   win;
  logic            win_found;

  // First valid requester searched upward from last+1, wrapping modulo NUM_REQ.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [IW-1:0]      last);
    logic [IW-1:0] pick;
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (v[(int'(last) + k) % NUM_REQ]) pick = IW'((int'(last) + k) % NUM_REQ);
    end
    return pick;
  endfunction

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    win_found = |req_valid;
`ifdef REGBUS_ARB_PRIO_EN
    win = req_valid[0] ? '0 : rr_pick(req_valid & ~LSB, last_grant);
`else
    win = rr_pick(req_valid, last_grant);
`endif
    req_ready = '0;
    // Gated by reset so the grant is also silent while the block is held in reset.
    if (S_AXI_ARESETN && state == IDLE && win_found) req_ready[win] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all updates take effect together at the edge.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      set_addr   <= '0;
      set_data   <= '0;
      set_stb    <= 1'b0;
      get_addr   <= '0;
      get_stb    <= 1'b0;
      rsp_rdata  <= '0;
      rsp_valid  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant <= win;
            busy  <= 1'b1;
            state <= ISSUE;
            if (req_we[win]) begin
              set_stb  <= 1'b1;
              set_addr <= DATA_WIDTH'(req_addr[win*ADDR_WIDTH +: ADDR_WIDTH]);
              set_data <= req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
            end else begin
              get_stb  <= 1'b1;
              get_addr <= DATA_WIDTH'(req_addr[win*ADDR_WIDTH +: ADDR_WIDTH]);
            end
          end
        end
        ISSUE: begin
          set_stb   <= 1'b0;
          get_stb   <= 1'b0;
          rsp_rdata <= get_stb ? get_data : '0;
          rsp_valid <= LSB << grant;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[grant]) begin
            rsp_valid  <= '0;
            busy       <= 1'b0;
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbus_arbiter.sv
// Scoreboard bench for regbus_arbiter: accepted requests queue expected strobes and responses.
// Grant order comes from a bench arbitration model; REGBUS_ARB_PRIO_EN selects the priority variant.
module tb_regbus_arbiter;
  localparam int NR = 2;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid, req_we, req_ready, rsp_valid, rsp_rdy;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, set_addr, set_data, get_addr, get_data;
  logic             set_stb, get_stb, busy;

  regbus_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_rdy), .rsp_rdata(rsp_rdata),
    .set_addr(set_addr), .set_data(set_data), .set_stb(set_stb),
    .get_addr(get_addr), .get_data(get_data), .get_stb(get_stb), .busy(busy)
  );

  // Register file model: one fixed location, everything else derived from the address.
  function automatic logic [DW-1:0] mem_rd(input logic [DW-1:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {~a[15:0], a[15:0]};
  endfunction
  assign get_data = mem_rd(get_addr);

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    int            id;
    bit            we;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] rdata;
    int            acc;
    bit            seen;
  } ent_t;

  op_t  op_q[NR][$];
  ent_t stb_q[$];
  ent_t rsp_q[$];
  int   grant_log[$];
  bit   acc_flag[NR];
  int   tb_last = NR - 1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic int model_pick(input logic [NR-1:0] v, input int last);
    int p;
    p = -1;
`ifdef REGBUS_ARB_PRIO_EN
    if (v[0]) return 0;
    v[0] = 1'b0;
`endif
    for (int k = 1; k <= NR; k++)
      if (p < 0 && v[(last + k) % NR]) p = (last + k) % NR;
    return p;
  endfunction

  task automatic drive_loop();
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (!rst_n) begin
          op_q[i].delete();
          acc_flag[i] = 1'b0;
        end else if (acc_flag[i]) begin
          void'(op_q[i].pop_front());
          acc_flag[i] = 1'b0;
        end
        if (op_q[i].size() != 0) begin
          req_valid[i]             = 1'b1;
          req_we[i]                = op_q[i][0].we;
          req_addr[i*AW +: AW]     = op_q[i][0].addr;
          req_wdata[i*DW +: DW]    = op_q[i][0].data;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic monitor_loop();
    ent_t e;
    bit   idle;
    int   g;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stb_q.delete();
        rsp_q.delete();
        tb_last = NR - 1;
        continue;
      end
      idle = (stb_q.size() == 0) && (rsp_q.size() == 0);
      check("busy", 64'(busy), 64'(!idle));
      if (rsp_q.size() != 0) begin
        e = rsp_q[0];
        check("rsp_valid", 64'(rsp_valid), 64'(onehot(e.id)));
        if (!e.seen) begin
          check("rsp_latency", 64'(cyc), 64'(e.acc + 2));
          rsp_q[0].seen = 1'b1;
        end
        if (rsp_rdy[e.id]) begin
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          tb_last = e.id;
          void'(rsp_q.pop_front());
        end
      end else begin
        check("rsp_idle", 64'(rsp_valid), 64'(0));
      end
      if (set_stb || get_stb) begin
        check("dual_stb", 64'(set_stb && get_stb), 64'(0));
        if (stb_q.size() == 0) begin
          check("spurious_stb", 64'(1), 64'(0));
        end else begin
          e = stb_q.pop_front();
          check("stb_cycle", 64'(cyc), 64'(e.acc + 1));
          if (e.we) begin
            check("set_stb", 64'(set_stb), 64'(1));
            check("set_addr", 64'(set_addr), 64'(e.addr));
            check("set_data", 64'(set_data), 64'(e.data));
          end else begin
            check("get_stb", 64'(get_stb), 64'(1));
            check("get_addr", 64'(get_addr), 64'(e.addr));
          end
          rsp_q.push_back(e);
        end
      end else if (stb_q.size() != 0) begin
        check("missing_stb", 64'(0), 64'(1));
        void'(stb_q.pop_front());
      end
      g = idle ? model_pick(req_valid, tb_last) : -1;
      check("req_ready", 64'(req_ready), (g < 0) ? 64'(0) : 64'(onehot(g)));
      if (g >= 0 && op_q[g].size() != 0) begin
        e.id    = g;
        e.we    = op_q[g][0].we;
        e.addr  = DW'(op_q[g][0].addr);
        e.data  = op_q[g][0].data;
        e.rdata = e.we ? '0 : mem_rd(DW'(op_q[g][0].addr));
        e.acc   = cyc;
        e.seen  = 1'b0;
        stb_q.push_back(e);
        acc_flag[g] = 1'b1;
        grant_log.push_back(g);
      end
    end
  endtask

  task automatic push_op(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t o;
    o.we = we; o.addr = a; o.data = d;
    op_q[i].push_back(o);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(posedge clk);
      #2;
      done = (op_q[0].size() == 0) && (op_q[1].size() == 0) && (req_valid == '0) &&
             (stb_q.size() == 0) && (rsp_q.size() == 0) && !busy;
    end
    if (!done) check("timeout_idle", 64'(0), 64'(1));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_rdy   = '1;
    fork
      drive_loop();
      monitor_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({set_stb, get_stb, busy, req_ready, rsp_valid}), 64'(0));
    check("reset_data", 64'(set_addr | set_data | get_addr | rsp_rdata), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single read and single write.
    push_op(0, 1'b0, 16'h0010, 32'h0);
    wait_idle();
    check("read_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
    push_op(1, 1'b1, 16'h0004, 32'h12345678);
    wait_idle();
    check("write_rdata", 64'(rsp_rdata), 64'(0));

    // Contention: both requesters keep four accesses queued.
    grant_log.delete();
    for (int k = 0; k < 4; k++) begin
      push_op(0, 1'b0, AW'(16'h0100 + k * 4), 32'h0);
      push_op(1, 1'b1, AW'(16'h0200 + k * 4), 32'hA000_0000 + 32'(k));
    end
    wait_idle();
    check("cont_count", 64'(grant_log.size()), 64'(8));
    if (grant_log.size() == 8) begin
`ifdef REGBUS_ARB_PRIO_EN
      for (int k = 0; k < 8; k++) check("prio_grant", 64'(grant_log[k]), 64'(k < 4 ? 0 : 1));
`else
      check("cont_first", 64'(grant_log[0]), 64'(0));
      for (int k = 1; k < 8; k++) check("alt_grant", 64'(grant_log[k] != grant_log[k-1]), 64'(1));
`endif
    end

    // Response back-pressure on requester 0 while requester 1 waits.
    rsp_rdy = 2'b10;
    push_op(0, 1'b0, 16'h0020, 32'h0);
    push_op(1, 1'b1, 16'h0008, 32'h5555AAAA);
    for (int t = 0; t < 20 && !rsp_valid[0]; t++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check("bp_hold", 64'(rsp_valid), 64'(2'b01));
    check("bp_no_ready", 64'(req_ready[1]), 64'(0));
    check("bp_no_stb", 64'(set_stb | get_stb), 64'(0));
    rsp_rdy = 2'b11;
    wait_idle();

    // Reset during the ISSUE cycle of a write, with last grant left at requester 0.
    push_op(0, 1'b0, 16'h0030, 32'h0);
    wait_idle();
    push_op(1, 1'b1, 16'h0034, 32'hCAFE0001);
    for (int t = 0; t < 20 && !set_stb; t++) begin
      @(posedge clk);
      #1;
    end
    check("rst_reach_issue", 64'(set_stb), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", 64'({set_stb, get_stb, busy, req_ready, rsp_valid}), 64'(0));
    check("rst_mid_data", 64'(set_addr | set_data | get_addr | rsp_rdata), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    grant_log.delete();
    push_op(0, 1'b0, 16'h0040, 32'h0);
    push_op(1, 1'b1, 16'h0044, 32'h0BADF00D);
    wait_idle();
    check("post_rst_count", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() != 0) check("post_rst_grant", 64'(grant_log[0]), 64'(0));

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
